tx_train_pattern_gen: RTL and testbench
=======================================

TX_TRAIN_PATTERN_GEN -- requirements
Module: tx_train_pattern_gen

Interface
REQ-001 The block SHALL have parameter CLK_TRAIN_WORDS, default 64, giving the number of clock-training words sent per training pass.
REQ-002 The block SHALL have parameter PRBS_MAX_WORDS, default 4096, giving the maximum number of PRBS words sent while waiting for RX_ALIGN_DONE.
REQ-003 The block SHALL have port TX_CLK_G, input, 1 bit: the single clock; all logic is rising-edge on it.
REQ-004 The block SHALL have port RESET, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port TRAIN_START, input, 1 bit: a one-cycle pulse that starts or restarts a training pass.
REQ-006 The block SHALL have port TRAIN_SKIP, input, 1 bit: a one-cycle pulse that jumps straight to the DATA state.
REQ-007 The block SHALL have port RX_ALIGN_DONE, input, 1 bit: far-end bit alignment complete, already synchronous to TX_CLK_G.
REQ-008 The block SHALL have port DATA_IN, input, 8 bits: the user payload word.
REQ-009 The block SHALL have port DATA_VALID, input, 1 bit: DATA_IN is valid.
REQ-010 The block SHALL have port DATA_READY, output, 1 bit: the block accepts DATA_IN this cycle.
REQ-011 The block SHALL have port TXD_WORD, output, 8 bits: the parallel word to the TX IOD serializer, MSB transmitted first.
REQ-012 The block SHALL have port TX_STATE, output, 2 bits: the current state encoding.
REQ-013 The block SHALL have port TRAIN_DONE, output, 1 bit: training is complete and the block is in the DATA state.
REQ-014 The block SHALL have port TRAIN_TIMEOUT, output, 1 bit: sticky flag set when the PRBS phase expires.

Function
REQ-015 The state machine SHALL have four states with encodings: IDLE=2'd0, CLK_TRAIN=2'd1, PRBS=2'd2, DATA=2'd3.
REQ-016 IDLE SHALL output TXD_WORD=8'h00 and DATA_READY=0; a TRAIN_START pulse moves it to CLK_TRAIN.
REQ-017 TXD_WORD, TX_STATE, TRAIN_DONE and DATA_READY SHALL all be registered: a TRAIN_START pulse in cycle n gives TX_STATE=1 and TXD_WORD=8'h55 in cycle n+1.
REQ-018 CLK_TRAIN SHALL emit exactly CLK_TRAIN_WORDS consecutive words of 8'h55, then enter PRBS on the next cycle.
REQ-019 PRBS SHALL emit PRBS7 data (x^7+x^6+1, seed 7'h7F, 8 bits per cycle, MSB first); the first word SHALL be 8'hFE and the second 8'h04.
REQ-020 The PRBS generator SHALL be reseeded to 7'h7F on every entry to PRBS.
REQ-021 In PRBS, RX_ALIGN_DONE=1 SHALL move the block to DATA on the next cycle; the PRBS word counter SHALL be cleared.
REQ-022 If PRBS_MAX_WORDS words have been sent without RX_ALIGN_DONE, the block SHALL go to IDLE and set TRAIN_TIMEOUT=1.
REQ-023 If RX_ALIGN_DONE rises in the same cycle the count expires, RX_ALIGN_DONE SHALL win: go to DATA, with no timeout.
REQ-024 TRAIN_TIMEOUT SHALL stay set until the next TRAIN_START or TRAIN_SKIP.
REQ-025 In DATA, TRAIN_DONE=1 and DATA_READY=1 SHALL hold.
REQ-026 In DATA, a word transfers when DATA_VALID and DATA_READY are both high in cycle n, and TXD_WORD=DATA_IN in cycle n+1; with no transfer TXD_WORD=8'h00.
REQ-027 TRAIN_START in any state SHALL restart the pass at CLK_TRAIN with counters cleared; in DATA, DATA_READY SHALL be 0 from the next cycle.
REQ-028 TRAIN_SKIP in any state SHALL move the block to DATA on the next cycle.
REQ-029 If TRAIN_START and TRAIN_SKIP arrive in the same cycle, TRAIN_SKIP SHALL win.
REQ-030 Counters SHALL be $clog2(param+1) bits wide and SHALL never wrap: each saturates at its terminal count.

Reset
REQ-031 While RESET=1 the block SHALL be asynchronously forced to: state IDLE, TXD_WORD=8'h00, DATA_READY=0, TRAIN_DONE=0, TRAIN_TIMEOUT=0, counters 0, PRBS state 7'h7F.
REQ-032 After RESET deasserts, the block SHALL stay in IDLE until TRAIN_START or TRAIN_SKIP.
REQ-033 RESET asserted mid-pass SHALL abort the pass with no partial-word carry-over.

Structure
REQ-034 A shared package tx_train_pkg SHALL hold the state typedef, the constants CLK_PATTERN=8'h55, IDLE_WORD=8'h00 and PRBS_SEED=7'h7F, and the polynomial taps.
REQ-035 The PRBS logic SHALL be a single sub-module prbs7_gen8 with clock, reset, load and enable inputs and an 8-bit word output.
REQ-036 The same prbs7_gen8 module SHALL be reusable by the receive-side checker.

Verification
REQ-037 Scenario: reset, then a TRAIN_START pulse with CLK_TRAIN_WORDS=4 -> TXD_WORD = 55,55,55,55,FE,04, with TX_STATE going 1 then 2.
REQ-038 Scenario: RX_ALIGN_DONE=1 on the 10th PRBS word -> TX_STATE=3, TRAIN_DONE=1 and DATA_READY=1 on the next cycle; DATA_IN=8'hA5 with DATA_VALID=1 -> TXD_WORD=A5 one cycle later.
REQ-039 Scenario: PRBS_MAX_WORDS=8 with RX_ALIGN_DONE held 0 -> after 8 PRBS words TX_STATE=0, TRAIN_TIMEOUT=1, and TXD_WORD=00 thereafter.
REQ-040 Scenario: TRAIN_START and TRAIN_SKIP in the same cycle from IDLE -> TX_STATE=3 next cycle, with no 8'h55 emitted.
REQ-041 Scenario: TRAIN_START in DATA while DATA_VALID=1 -> DATA_READY=0 next cycle, TXD_WORD=55, and the pending word is not transmitted.
REQ-042 Scenario: RESET asserted for one cycle during PRBS -> outputs return to reset values immediately; the next pass begins with PRBS word FE.

Source files
------------

// File: rtl/tx_train_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_train_pkg
//  Description : Shared types, constants and PRBS7 stepping function for the
//                link-training transmit path and its receive-side checker.
//  Revision    : 1.0  initial release
// ============================================================================
package tx_train_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLK_TRAIN = 2'd1,
        ST_PRBS      = 2'd2,
        ST_DATA      = 2'd3
    } tx_state_t;

    localparam logic [7:0] CLK_PATTERN = 8'h55;
    localparam logic [7:0] IDLE_WORD   = 8'h00;
    localparam logic [6:0] PRBS_SEED   = 7'h7F;

    // x^7 + x^6 + 1: feedback taken from register bits 6 and 5.
    localparam int PRBS_TAP_HI = 6;
    localparam int PRBS_TAP_LO = 5;

    typedef struct packed {
        logic [6:0] state;
        logic [7:0] word;
    } prbs_step_t;

    // Advance the Fibonacci register by eight bits. The bit leaving the top
    // of the register is transmitted; the first bit out lands in word[7].
    function automatic prbs_step_t prbs7_advance8(input logic [6:0] state);
        prbs_step_t r;
        logic [6:0] s;
        s      = state;
        r.word = '0;
        for (int b = 7; b >= 0; b--) begin
            r.word[b] = s[6];
            s         = {s[5:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
        end
        r.state = s;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs7_gen8.sv
`default_nettype none
// ============================================================================
//  Module      : prbs7_gen8
//  Description : PRBS7 (x^7+x^6+1) generator producing 8 bits per clock,
//                MSB first. Shared by the TX pattern generator and RX checker.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk_i   : clock, rising edge
//    rst_i   : asynchronous active-high reset, loads the seed
//    load_i  : reload the seed (priority over en_i)
//    en_i    : advance the register by one word
//    word_o  : word produced from the current register contents
// ============================================================================
module prbs7_gen8 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_i,
    input  logic       en_i,
    output logic [7:0] word_o
);
    import tx_train_pkg::*;

    logic [6:0] lfsr_q;
    prbs_step_t w_step;

    assign w_step = prbs7_advance8(lfsr_q);
    assign word_o = w_step.word;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= PRBS_SEED;
        end else if (load_i) begin
            lfsr_q <= PRBS_SEED;
        end else if (en_i) begin
            lfsr_q <= w_step.state;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tx_train_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tx_train_pattern_gen
//  Description : Link-training transmit sequencer. Sends a clock pattern,
//                then PRBS7 until the far end reports alignment (or a word
//                budget expires), then passes user payload through.
//  Revision    : 1.0  initial release
//
//  Ports
//    TX_CLK_G      : clock, rising edge
//    RESET         : asynchronous active-high reset
//    TRAIN_START   : pulse, start/restart a training pass
//    TRAIN_SKIP    : pulse, go straight to DATA (wins over TRAIN_START)
//    RX_ALIGN_DONE : far-end alignment complete (synchronous)
//    DATA_IN       : payload word
//    DATA_VALID    : DATA_IN valid
//    DATA_READY    : payload accepted this cycle (registered)
//    TXD_WORD      : serializer word, MSB first (registered)
//    TX_STATE      : 0 IDLE, 1 CLK_TRAIN, 2 PRBS, 3 DATA
//    TRAIN_DONE    : in DATA state
//    TRAIN_TIMEOUT : sticky, PRBS budget expired
// ============================================================================
module tx_train_pattern_gen #(
    parameter int CLK_TRAIN_WORDS = 64,
    parameter int PRBS_MAX_WORDS  = 4096
) (
    input  logic       TX_CLK_G,
    input  logic       RESET,
    input  logic       TRAIN_START,
    input  logic       TRAIN_SKIP,
    input  logic       RX_ALIGN_DONE,
    input  logic [7:0] DATA_IN,
    input  logic       DATA_VALID,
    output logic       DATA_READY,
    output logic [7:0] TXD_WORD,
    output logic [1:0] TX_STATE,
    output logic       TRAIN_DONE,
    output logic       TRAIN_TIMEOUT
);
    import tx_train_pkg::*;

    localparam int CLK_CNT_W  = $clog2(CLK_TRAIN_WORDS + 1);
    localparam int PRBS_CNT_W = $clog2(PRBS_MAX_WORDS + 1);

    localparam logic [CLK_CNT_W-1:0]  CLK_CNT_LAST  = CLK_CNT_W'(CLK_TRAIN_WORDS);
    localparam logic [CLK_CNT_W-1:0]  CLK_CNT_ONE   = CLK_CNT_W'(1);
    localparam logic [PRBS_CNT_W-1:0] PRBS_CNT_LAST = PRBS_CNT_W'(PRBS_MAX_WORDS);
    localparam logic [PRBS_CNT_W-1:0] PRBS_CNT_ONE  = PRBS_CNT_W'(1);

    tx_state_t              state_q,    state_d;
    logic [7:0]             txd_q,      txd_d;
    logic [CLK_CNT_W-1:0]   clk_cnt_q,  clk_cnt_d;
    logic [PRBS_CNT_W-1:0]  prbs_cnt_q, prbs_cnt_d;
    logic                   timeout_q,  timeout_d;
    logic                   ready_q,    ready_d;
    logic                   done_q,     done_d;

    logic                   w_xfer;
    logic                   w_prbs_load;
    logic                   w_prbs_en;
    logic [7:0]             w_prbs_word;

    // The generator sits at the seed whenever the next state is not PRBS,
    // so every entry into PRBS starts from the seed word.
    assign w_prbs_load = (state_d != ST_PRBS);
    assign w_prbs_en   = (state_d == ST_PRBS);

    prbs7_gen8 u_prbs (
        .clk_i  (TX_CLK_G),
        .rst_i  (RESET),
        .load_i (w_prbs_load),
        .en_i   (w_prbs_en),
        .word_o (w_prbs_word)
    );

    // READY is registered and only high in DATA, so this is the handshake.
    assign w_xfer = DATA_VALID & ready_q;

    always_comb begin
        state_d    = state_q;
        txd_d      = IDLE_WORD;
        clk_cnt_d  = clk_cnt_q;
        prbs_cnt_d = prbs_cnt_q;
        timeout_d  = timeout_q;

        if (TRAIN_SKIP) begin
            state_d    = ST_DATA;
            txd_d      = w_xfer ? DATA_IN : IDLE_WORD;
            clk_cnt_d  = '0;
            prbs_cnt_d = '0;
            timeout_d  = 1'b0;
        end else if (TRAIN_START) begin
            // The first pattern word goes out on the entry cycle.
            state_d    = ST_CLK_TRAIN;
            txd_d      = CLK_PATTERN;
            clk_cnt_d  = CLK_CNT_ONE;
            prbs_cnt_d = '0;
            timeout_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_d = IDLE_WORD;
                end
                ST_CLK_TRAIN: begin
                    if (clk_cnt_q >= CLK_CNT_LAST) begin
                        state_d    = ST_PRBS;
                        txd_d      = w_prbs_word;
                        clk_cnt_d  = '0;
                        prbs_cnt_d = PRBS_CNT_ONE;
                    end else begin
                        txd_d     = CLK_PATTERN;
                        clk_cnt_d = clk_cnt_q + CLK_CNT_ONE;
                    end
                end
                ST_PRBS: begin
                    // Alignment is tested first so it beats expiry.
                    if (RX_ALIGN_DONE) begin
                        state_d    = ST_DATA;
                        prbs_cnt_d = '0;
                    end else if (prbs_cnt_q >= PRBS_CNT_LAST) begin
                        state_d    = ST_IDLE;
                        prbs_cnt_d = '0;
                        timeout_d  = 1'b1;
                    end else begin
                        txd_d      = w_prbs_word;
                        prbs_cnt_d = prbs_cnt_q + PRBS_CNT_ONE;
                    end
                end
                ST_DATA: begin
                    txd_d = w_xfer ? DATA_IN : IDLE_WORD;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        ready_d = (state_d == ST_DATA);
        done_d  = (state_d == ST_DATA);
    end

    always_ff @(posedge TX_CLK_G or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            txd_q      <= IDLE_WORD;
            clk_cnt_q  <= '0;
            prbs_cnt_q <= '0;
            timeout_q  <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            txd_q      <= txd_d;
            clk_cnt_q  <= clk_cnt_d;
            prbs_cnt_q <= prbs_cnt_d;
            timeout_q  <= timeout_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign TXD_WORD      = txd_q;
    assign TX_STATE      = state_q;
    assign DATA_READY    = ready_q;
    assign TRAIN_DONE    = done_q;
    assign TRAIN_TIMEOUT = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_tx_train_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tx_train_pattern_gen
//  Description : Self-checking bench for tx_train_pattern_gen. Two instances
//                with different PRBS budgets share one stimulus stream and are
//                each compared against a behavioural model every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tx_train_pattern_gen;

    localparam int CT_A = 4;
    localparam int PM_A = 8;
    localparam int CT_B = 4;
    localparam int PM_B = 16;

    logic       clk = 1'b0;
    logic       tb_rst = 1'b1;
    logic       tb_start = 1'b0;
    logic       tb_skip = 1'b0;
    logic       tb_align = 1'b0;
    logic [7:0] tb_din = 8'h00;
    logic       tb_dv = 1'b0;

    wire        a_rdy, a_done, a_to, b_rdy, b_done, b_to;
    wire [7:0]  a_txd, b_txd;
    wire [1:0]  a_state, b_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    tx_train_pattern_gen #(.CLK_TRAIN_WORDS(CT_A), .PRBS_MAX_WORDS(PM_A)) dut_a (
        .TX_CLK_G(clk), .RESET(tb_rst), .TRAIN_START(tb_start), .TRAIN_SKIP(tb_skip),
        .RX_ALIGN_DONE(tb_align), .DATA_IN(tb_din), .DATA_VALID(tb_dv),
        .DATA_READY(a_rdy), .TXD_WORD(a_txd), .TX_STATE(a_state),
        .TRAIN_DONE(a_done), .TRAIN_TIMEOUT(a_to)
    );

    tx_train_pattern_gen #(.CLK_TRAIN_WORDS(CT_B), .PRBS_MAX_WORDS(PM_B)) dut_b (
        .TX_CLK_G(clk), .RESET(tb_rst), .TRAIN_START(tb_start), .TRAIN_SKIP(tb_skip),
        .RX_ALIGN_DONE(tb_align), .DATA_IN(tb_din), .DATA_VALID(tb_dv),
        .DATA_READY(b_rdy), .TXD_WORD(b_txd), .TX_STATE(b_state),
        .TRAIN_DONE(b_done), .TRAIN_TIMEOUT(b_to)
    );

    // ---------------------------------------------------------------- model
    // PRBS7 output bit stream from the recurrence o[n] = o[n-7] ^ o[n-6],
    // first seven bits all ones (seed 7F); period 127.
    logic prbs_bits[127];

    int         m_ct[2] = '{CT_A, CT_B};
    int         m_pm[2] = '{PM_A, PM_B};
    logic [1:0] m_ph[2];
    int         m_cnt[2];
    logic [7:0] m_txd[2];
    logic       m_rdy[2];
    logic       m_to[2];

    function automatic logic [7:0] prbs_word(int k);
        logic [7:0] w;
        for (int j = 0; j < 8; j++) w[7-j] = prbs_bits[(8*k + j) % 127];
        return w;
    endfunction

    task automatic model_reset(int i);
        m_ph[i] = 2'd0; m_cnt[i] = 0; m_txd[i] = 8'h00; m_rdy[i] = 1'b0; m_to[i] = 1'b0;
    endtask

    // One clock of behaviour: m_cnt holds how many words the current phase
    // has put on the wire so far.
    task automatic model_step(int i);
        logic xfer;
        xfer = tb_dv && m_rdy[i];
        if (tb_skip) begin
            m_ph[i] = 2'd3; m_txd[i] = xfer ? tb_din : 8'h00; m_cnt[i] = 0; m_to[i] = 1'b0;
        end else if (tb_start) begin
            m_ph[i] = 2'd1; m_txd[i] = 8'h55; m_cnt[i] = 1; m_to[i] = 1'b0;
        end else begin
            case (m_ph[i])
                2'd1: begin
                    if (m_cnt[i] == m_ct[i]) begin
                        m_ph[i] = 2'd2; m_txd[i] = prbs_word(0); m_cnt[i] = 1;
                    end else begin
                        m_txd[i] = 8'h55; m_cnt[i]++;
                    end
                end
                2'd2: begin
                    if (tb_align) begin
                        m_ph[i] = 2'd3; m_txd[i] = 8'h00; m_cnt[i] = 0;
                    end else if (m_cnt[i] == m_pm[i]) begin
                        m_ph[i] = 2'd0; m_txd[i] = 8'h00; m_cnt[i] = 0; m_to[i] = 1'b1;
                    end else begin
                        m_txd[i] = prbs_word(m_cnt[i]); m_cnt[i]++;
                    end
                end
                2'd3:    m_txd[i] = xfer ? tb_din : 8'h00;
                default: m_txd[i] = 8'h00;
            endcase
        end
        m_rdy[i] = (m_ph[i] == 2'd3);
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (tb_rst) model_reset(i);
            else        model_step(i);
        end
        #1;
    endtask

    function automatic logic [12:0] dut_vec(int i);
        if (i == 0) return {a_state, a_txd, a_rdy, a_done, a_to};
        return {b_state, b_txd, b_rdy, b_done, b_to};
    endfunction

    function automatic logic [12:0] exp_vec(int i);
        return {m_ph[i], m_txd[i], m_rdy[i], m_rdy[i], m_to[i]};
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        tb_rst = 1'b1;
        model_reset(0); model_reset(1);
        #3;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (dut_vec(i) !== 13'h0) begin
                n_errors++;
                $display("FAIL reset_values dut%0d: got %h expected %h", i, dut_vec(i), 13'h0);
            end
        end
        tick(); tick();
        tb_rst = 1'b0;
        repeat (3) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    n_errors++;
                    $display("FAIL idle_after_reset dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_clk_train();
        logic [7:0] exp_w[6];
        logic [1:0] exp_s[6];
        exp_w = '{8'h55, 8'h55, 8'h55, 8'h55, 8'hFE, 8'h04};
        exp_s = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (a_txd !== exp_w[k] || a_state !== exp_s[k]) begin
                n_errors++;
                $display("FAIL clk_train_seq word%0d: got %h/%0d expected %h/%0d", k, a_txd, a_state, exp_w[k], exp_s[k]);
            end
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    n_errors++;
                    $display("FAIL clk_train_model dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
            tick();
        end
    endtask

    task automatic test_align();
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        // Word 1 is on the wire now; 13 more cycles puts PRBS word 10 out.
        repeat (13) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    n_errors++;
                    $display("FAIL align_model dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
        end
        n_checks++;
        if (b_state !== 2'd2 || b_txd !== prbs_word(9)) begin
            n_errors++;
            $display("FAIL align_word10: got %0d/%h expected 2/%h", b_state, b_txd, prbs_word(9));
        end
        tb_align = 1'b1; tb_dv = 1'b1; tb_din = 8'h5A;
        tick();
        tb_align = 1'b0; tb_din = 8'hA5;
        n_checks++;
        if (b_state !== 2'd3 || b_done !== 1'b1 || b_rdy !== 1'b1 || b_txd !== 8'h00 || b_to !== 1'b0) begin
            n_errors++;
            $display("FAIL align_enter_data: got st=%0d done=%b rdy=%b txd=%h to=%b expected 3 1 1 00 0", b_state, b_done, b_rdy, b_txd, b_to);
        end
        tick();
        tb_dv = 1'b0;
        n_checks++;
        if (b_txd !== 8'hA5) begin
            n_errors++;
            $display("FAIL data_passthrough: got %h expected a5", b_txd);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                n_errors++;
                $display("FAIL align_data_model dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
            end
        end
        tick();
    endtask

    task automatic test_timeout();
        int prbs_seen;
        prbs_seen = 0;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        for (int c = 0; c < CT_A + PM_A + 4; c++) begin
            if (a_state == 2'd2) prbs_seen++;
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    n_errors++;
                    $display("FAIL timeout_model dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
            tick();
        end
        n_checks++;
        if (prbs_seen != PM_A || a_state !== 2'd0 || a_to !== 1'b1 || a_txd !== 8'h00) begin
            n_errors++;
            $display("FAIL timeout_expiry: got words=%0d st=%0d to=%b txd=%h expected %0d 0 1 00", prbs_seen, a_state, a_to, a_txd, PM_A);
        end
        repeat (12) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    n_errors++;
                    $display("FAIL timeout_sticky_model dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_start_skip();
        tb_start = 1'b1; tb_skip = 1'b1;
        tick();
        tb_start = 1'b0; tb_skip = 1'b0;
        n_checks++;
        if (a_state !== 2'd3 || b_state !== 2'd3 || a_txd !== 8'h00 || b_txd !== 8'h00 || a_to !== 1'b0 || b_to !== 1'b0) begin
            n_errors++;
            $display("FAIL start_skip_same_cycle: got st=%0d/%0d txd=%h/%h to=%b/%b expected 3/3 00/00 0/0", a_state, b_state, a_txd, b_txd, a_to, b_to);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                n_errors++;
                $display("FAIL start_skip_model dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_restart_in_data();
        tb_dv = 1'b1; tb_din = 8'h3C;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                n_errors++;
                $display("FAIL data_xfer_model dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
            end
        end
        tb_start = 1'b1; tb_din = 8'hC3;
        tick();
        tb_start = 1'b0; tb_dv = 1'b0;
        n_checks++;
        if (a_rdy !== 1'b0 || b_rdy !== 1'b0 || a_txd !== 8'h55 || b_txd !== 8'h55 || a_state !== 2'd1) begin
            n_errors++;
            $display("FAIL restart_in_data: got rdy=%b/%b txd=%h/%h st=%0d expected 0/0 55/55 1", a_rdy, b_rdy, a_txd, b_txd, a_state);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (dut_vec(i) !== exp_vec(i)) begin
                n_errors++;
                $display("FAIL restart_model dut%0d: got %h expected %h", i, dut_vec(i), exp_vec(i));
            end
        end
    endtask

    task automatic test_reset_mid_prbs();
        repeat (6) tick();
        n_checks++;
        if (a_state !== 2'd2) begin
            n_errors++;
            $display("FAIL reset_mid_prbs_setup: got st=%0d expected 2", a_state);
        end
        tb_rst = 1'b1;
        #2;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (dut_vec(i) !== 13'h0) begin
                n_errors++;
                $display("FAIL async_reset dut%0d: got %h expected %h", i, dut_vec(i), 13'h0);
            end
        end
        model_reset(0); model_reset(1);
        tick();
        tb_rst = 1'b0;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        repeat (CT_A) tick();
        n_checks++;
        if (a_txd !== 8'hFE || b_txd !== 8'hFE || a_state !== 2'd2) begin
            n_errors++;
            $display("FAIL prbs_reseed_after_reset: got %h/%h st=%0d expected fe/fe 2", a_txd, b_txd, a_state);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tb_start = ($urandom_range(0, 29) == 0);
            tb_skip  = ($urandom_range(0, 49) == 0);
            tb_align = ($urandom_range(0, 9) == 0);
            tb_dv    = ($urandom_range(0, 1) == 1);
            tb_din   = 8'($urandom);
            tb_rst   = ($urandom_range(0, 199) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (dut_vec(i) !== exp_vec(i)) begin
                    n_errors++;
                    $display("FAIL random_model cyc%0d dut%0d: got %h expected %h", c, i, dut_vec(i), exp_vec(i));
                end
            end
        end
        tb_start = 1'b0; tb_skip = 1'b0; tb_align = 1'b0; tb_dv = 1'b0; tb_rst = 1'b0;
        tick();
    endtask

    initial begin
        prbs_bits[0] = 1'b1;
        for (int n = 1; n < 127; n++)
            prbs_bits[n] = (n < 7) ? 1'b1 : (prbs_bits[n-7] ^ prbs_bits[n-6]);
        model_reset(0); model_reset(1);

        test_reset();
        test_clk_train();
        test_align();
        test_timeout();
        test_start_skip();
        test_restart_in_data();
        test_reset_mid_prbs();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
